// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the 5-stage ARM pipeline.
// Fetch state encoding, default PC step and IF/ID bubble values.
package arm_pipe_pkg;

  typedef enum logic {
    S_FETCH,
    S_HELD
  } fetch_state_t;

  localparam int PC_STEP_DEF = 4;

  localparam logic        BUBBLE_VALID = 1'b0;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, load, bubble and hold.
// Flush and reset both clear the register to a bubble.
module if_id_reg
  import arm_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] instr_in,
  output logic [W-1:0] pc_out,
  output logic [W-1:0] instr_out,
  output logic         valid_out
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out    <= '0;
      instr_out <= W'(BUBBLE_INSTR);
      valid_out <= BUBBLE_VALID;
    end else if (load) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid_out <= 1'b1;
    end else if (bubble) begin
      valid_out <= BUBBLE_VALID;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, skid buffer, IF/ID register.
// Optional IF_FETCH_PERF_CNT_EN adds stall_cycles/fetch_count outputs.
module if_fetch_stage
  import arm_pipe_pkg::*;
#(
  parameter int                    BIT_NUMBER = 32,
  parameter logic [BIT_NUMBER-1:0] PC_RESET   = '0,
  parameter int                    PC_STEP    = PC_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [BIT_NUMBER-1:0] imem_rdata,
  output logic [BIT_NUMBER-1:0] pc_out,
  output logic [BIT_NUMBER-1:0] instr_out,
  output logic                  valid_out
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           fetch_count
`endif
);

  fetch_state_t          state;
  logic [BIT_NUMBER-1:0] pc;
  logic [BIT_NUMBER-1:0] skid;
  logic [BIT_NUMBER-1:0] pc_inc;
  logic [BIT_NUMBER-1:0] ld_instr;
  logic                  held;
  logic                  xfer;
  logic                  load;
  logic                  bubble;

  assign held      = (state == S_HELD);
  assign imem_req  = !rst && !held;
  assign imem_addr = pc;
  assign xfer      = imem_req && imem_ready;
  assign pc_inc    = pc + BIT_NUMBER'(PC_STEP);
  assign ld_instr  = held ? skid : imem_rdata;

  assign load   = !branch_taken && !freeze && (held || xfer);
  assign bubble = !branch_taken && !freeze && !held && !xfer;

  // A word fetched under freeze parks in skid; pc keeps pointing at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= PC_RESET;
      state <= S_FETCH;
      skid  <= '0;
    end else if (branch_taken) begin
      pc    <= branch_addr;
      state <= S_FETCH;
      skid  <= '0;
    end else if (load) begin
      pc    <= pc_inc;
      state <= S_FETCH;
    end else if (freeze && xfer) begin
      skid  <= imem_rdata;
      state <= S_HELD;
    end
  end

  if_id_reg #(
    .W(BIT_NUMBER)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (branch_taken),
    .load     (load),
    .bubble   (bubble),
    .pc_in    (pc_inc),
    .instr_in (ld_instr),
    .pc_out   (pc_out),
    .instr_out(instr_out),
    .valid_out(valid_out)
  );

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      fetch_count  <= '0;
    end else begin
      if (freeze && !branch_taken && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (load && fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage ARM pipeline.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Honours freeze from the hazard detection unit (stall) and branch_taken from EXE (redirect and flush).
- Feeds instruction and PC+4 to the ID stage; a one-entry skid buffer keeps a fetched word while frozen.

Parameters:
- BIT_NUMBER, 32, datapath/PC/instruction width
- PC_RESET, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per instruction (bytes)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  stall request from hazard unit (hazard_Detected); hold IF/ID and PC
- branch_taken  in  1  EXE-stage branch resolved taken; redirect and flush
- branch_addr  in  BIT_NUMBER  branch target
- imem_req  out  1  fetch request valid
- imem_addr  out  BIT_NUMBER  fetch address (= pc)
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  BIT_NUMBER  fetched instruction
- pc_out  out  BIT_NUMBER  IF/ID: address of instruction + PC_STEP
- instr_out  out  BIT_NUMBER  IF/ID: instruction word
- valid_out  out  1  IF/ID: instruction valid (0 = bubble)

Behaviour:
- Reset, all synchronous on rst=1:
  - pc<=PC_RESET, state<=S_FETCH.
  - pc_out, instr_out, valid_out <= 0; skid buffer cleared.
  - imem_req=0 while rst=1.
- States:
  - S_FETCH: imem_req=1, imem_addr=pc.
  - S_HELD: word is buffered; imem_req=0, imem_addr=pc.
- Memory handshake:
  - A transfer occurs on a cycle with imem_req=1 and imem_ready=1, rdata valid that same cycle.
  - Latency is 0..N cycles.
  - Memory samples imem_addr every cycle, so an address change abandons the outstanding request.
- Priority per cycle: rst > branch_taken > freeze > normal.
- branch_taken=1, regardless of state or freeze:
  - pc<=branch_addr; valid_out<=0, instr_out<=0, pc_out<=0.
  - Skid buffer discarded; state<=S_FETCH.
  - Any imem_rdata arriving that cycle is dropped.
- S_FETCH, transfer, freeze=0: pc_out<=pc+PC_STEP, instr_out<=imem_rdata, valid_out<=1, pc<=pc+PC_STEP.
- S_FETCH, transfer, freeze=1: IF/ID unchanged; skid<=imem_rdata; pc unchanged; state<=S_HELD.
- S_FETCH, no transfer:
  - freeze=0: valid_out<=0 (bubble); pc_out/instr_out hold.
  - freeze=1: IF/ID unchanged.
- S_HELD:
  - freeze=1: hold everything.
  - freeze=0: pc_out<=pc+PC_STEP, instr_out<=skid, valid_out<=1, pc<=pc+PC_STEP, state<=S_FETCH.
- Throughput: one instruction per cycle when imem_ready is held high and freeze=0; no instruction is lost or duplicated across a freeze.
- PC arithmetic is modulo 2^BIT_NUMBER and wraps silently at top of address space.
- Reset mid-request abandons the fetch; first post-reset request goes to PC_RESET.

Optional Feature:
- Macro IF_FETCH_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and fetch_count[31:0]:
  - stall_cycles: +1 on each cycle with freeze=1 and branch_taken=0.
  - fetch_count: +1 on each IF/ID load with valid_out<=1.
  - Both cleared by rst; both saturate at all-ones.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - fetch state enum {S_FETCH, S_HELD}.
  - PC_STEP default constant.
  - IF/ID bubble constants (instr 0, valid 0).
- One sub-module, if_id_reg: IF/ID register with load/hold/flush controls.
- PC, FSM and skid buffer stay in if_fetch_stage.

Test Plan:
- Reset release, imem_ready=1 constant, rdata=addr-derived: imem_addr sequence 0,4,8,…; valid_out=1 from cycle 2; pc_out = addr+4.
- imem_ready low 3 cycles at addr 0x10: imem_addr holds 0x10; valid_out=0 for 3 cycles; then instr for 0x10 with pc_out=0x14.
- freeze high 2 cycles on a cycle where rdata(0x20) returns: IF/ID holds prior instr; state S_HELD; after freeze drops, instr_out=rdata(0x20), pc_out=0x24, next imem_addr=0x24.
- branch_taken with branch_addr=0x100 while freeze=1 and S_HELD: next cycle valid_out=0, imem_addr=0x100, skid word never appears.
- PC=0xFFFFFFFC fetched: next imem_addr=0x00000000, pc_out=0x00000000.
- rst asserted while imem_ready=0 at addr 0x40: imem_req=0 during reset; outputs 0; first request after reset at PC_RESET. With IF_FETCH_PERF_CNT_EN, counters read 0.
